// File: rtl/reg_out_fifo.sv
// Output-register FIFO at the machine boundary: captures fire-and-forget result
// words, buffers up to DEPTH of them, and hands them out over valid/ready.
module reg_out_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [1:0]        state
);

  // Handshake: a word moves out on a clock edge where out_valid and out_ready
  // are both high; out_data holds steady while out_valid=1 and out_ready=0.
  // The producer side has no backpressure: words arriving while full are dropped.

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t              st;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                push;
  logic                pop;
  logic                drop;
  logic [LW-1:0]       level_nxt;

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign full      = (st == ST_FULL);
  assign state     = st;

  assign pop  = out_valid & out_ready & ~flush;
  assign push = in_valid & ~flush & (~full | pop);
  assign drop = in_valid & ~flush & full & ~pop;

  always_comb begin
    level_nxt = level;
    if (push && !pop) level_nxt = level + LW'(1);
    else if (pop && !push) level_nxt = level - LW'(1);
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      st       <= ST_EMPTY;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      st       <= ST_EMPTY;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (level_nxt == '0)                st <= ST_EMPTY;
      else if (level_nxt == LW'(DEPTH))   st <= ST_FULL;
      else                                st <= ST_PARTIAL;
    end
  end

endmodule

// File: tb/tb_reg_out_fifo.sv
// Directed bench for reg_out_fifo (DEPTH=4, CNT_W=2 so drop saturation is reachable).
module tb_reg_out_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int LW     = $clog2(DEPTH + 1);

  logic              clock;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [LW-1:0]     level;
  logic              full;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
  logic [1:0]        state;

  int checks;
  int failures;
  logic [DATA_W-1:0] exp_q[$];

  reg_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .full(full), .overflow(overflow), .drop_cnt(drop_cnt),
    .state(state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 3'd0 || full !== 1'b0 ||
        overflow !== 1'b0 || drop_cnt !== 2'd0 || state !== 2'd0) begin
      failures++;
      $display("FAIL reset: v=%b d=%h lvl=%0d full=%b ovf=%b drop=%0d st=%0d, want all 0",
               out_valid, out_data, level, full, overflow, drop_cnt, state);
    end
  endtask

  task automatic test_pass_through();
    logic [DATA_W-1:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== words[i] || level !== 3'd1 || state !== 2'd1) begin
        failures++;
        $display("FAIL pass_through[%0d]: v=%b d=%h lvl=%0d st=%0d, want v=1 d=%h lvl=1 st=1",
                 i, out_valid, out_data, level, state, words[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 3'd0) begin
      failures++;
      $display("FAIL pass_through_end: v=%b d=%h lvl=%0d, want 0 0 0", out_valid, out_data, level);
    end
  endtask

  task automatic test_fill_overflow();
    logic [DATA_W-1:0] w;
    idle();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      tick();
      if (i == 3) begin
        checks++;
        if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0 || state !== 2'd2) begin
          failures++;
          $display("FAIL fill_full: full=%b lvl=%0d ovf=%b st=%0d, want 1 4 0 2",
                   full, level, overflow, state);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 2'd2 || level !== 3'd4 || out_data !== 8'hA0) begin
      failures++;
      $display("FAIL fill_overflow: ovf=%b drop=%0d lvl=%0d d=%h, want 1 2 4 a0",
               overflow, drop_cnt, level, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 8'hA0 + 8'(i);
      checks++;
      if (out_valid !== 1'b1 || out_data !== w) begin
        failures++;
        $display("FAIL drain[%0d]: v=%b d=%h, want v=1 d=%h", i, out_valid, out_data, w);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || drop_cnt !== 2'd2 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL drain_end: v=%b lvl=%0d drop=%0d ovf=%b, want 0 0 2 1",
               out_valid, level, drop_cnt, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] want [4];
    want[0] = 8'hC1; want[1] = 8'hC2; want[2] = 8'hC3; want[3] = 8'hB0;
    do_flush();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      tick();
    end
    out_ready = 1'b1; in_data = 8'hB0;
    tick();
    checks++;
    if (level !== 3'd4 || full !== 1'b1 || drop_cnt !== 2'd0 || overflow !== 1'b0 ||
        out_data !== 8'hC1) begin
      failures++;
      $display("FAIL full_push_pop: lvl=%0d full=%b drop=%0d ovf=%b d=%h, want 4 1 0 0 c1",
               level, full, drop_cnt, overflow, out_data);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== want[i]) begin
        failures++;
        $display("FAIL full_push_pop_drain[%0d]: v=%b d=%h, want 1 %h", i, out_valid, out_data, want[i]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || state !== 2'd0) begin
      failures++;
      $display("FAIL full_push_pop_end: v=%b st=%0d, want 0 0", out_valid, state);
    end
  endtask

  // Scoreboarded wrap-around run with random out_ready and a small reference model.
  task automatic test_wrap_around();
    int sent;
    int got;
    int cycles;
    int model_drops;
    logic m_pop;
    logic m_push;
    logic [DATA_W-1:0] exp_d;
    do_flush();
    exp_q.delete();
    sent = 0; got = 0; cycles = 0; model_drops = 0;
    while ((sent < 3*DEPTH || exp_q.size() != 0) && cycles < 400) begin
      in_valid  = (sent < 3*DEPTH) && ($urandom_range(0, 3) != 0);
      in_data   = 8'h40 + 8'(sent);
      out_ready = (sent >= 3*DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      m_pop  = (exp_q.size() != 0) && out_ready;
      m_push = in_valid && ((exp_q.size() < DEPTH) || m_pop);
      checks++;
      if (out_valid !== (exp_q.size() != 0) || level !== LW'(exp_q.size())) begin
        failures++;
        $display("FAIL wrap_level: v=%b lvl=%0d, want v=%b lvl=%0d",
                 out_valid, level, exp_q.size() != 0, exp_q.size());
      end
      if (m_pop) begin
        exp_d = exp_q.pop_front();
        got++;
        checks++;
        if (out_data !== exp_d) begin
          failures++;
          $display("FAIL wrap_data[%0d]: d=%h, want %h", got, out_data, exp_d);
        end
      end
      if (m_push) begin
        exp_q.push_back(in_data);
        sent++;
      end else if (in_valid) begin
        model_drops++;
      end
      tick();
      cycles++;
    end
    idle();
    checks++;
    if (cycles >= 400 || got != 3*DEPTH || out_valid !== 1'b0 ||
        drop_cnt !== CNT_W'(model_drops > 3 ? 3 : model_drops)) begin
      failures++;
      $display("FAIL wrap_end: cycles=%0d got=%0d v=%b drop=%0d, want got=%0d v=0 drop=%0d",
               cycles, got, out_valid, drop_cnt, 3*DEPTH, model_drops);
    end
  endtask

  task automatic test_flush_saturation();
    do_flush();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 8'h60 + 8'(i);
      tick();
    end
    checks++;
    if (drop_cnt !== 2'd3 || overflow !== 1'b1 || level !== 3'd4 || out_data !== 8'h60) begin
      failures++;
      $display("FAIL saturate: drop=%0d ovf=%b lvl=%0d d=%h, want 3 1 4 60",
               drop_cnt, overflow, level, out_data);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    tick();
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 2'd0 ||
        out_data !== 8'h00 || full !== 1'b0 || state !== 2'd0) begin
      failures++;
      $display("FAIL flush: lvl=%0d v=%b ovf=%b drop=%0d d=%h full=%b st=%0d, want all 0",
               level, out_valid, overflow, drop_cnt, out_data, full, state);
    end
    idle();
    tick();
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      failures++;
      $display("FAIL flush_word_absent: v=%b lvl=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h70 + 8'(i);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 3'd0 || full !== 1'b0 ||
        overflow !== 1'b0 || drop_cnt !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: v=%b d=%h lvl=%0d full=%b ovf=%b drop=%0d, want all 0",
               out_valid, out_data, level, full, overflow, drop_cnt);
    end
    idle();
    #1;
    reset_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || level !== 3'd1) begin
      failures++;
      $display("FAIL post_reset_push: v=%b d=%h lvl=%0d, want 1 5a 1", out_valid, out_data, level);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      failures++;
      $display("FAIL post_reset_alone: v=%b lvl=%0d, want 0 0", out_valid, level);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b1;
    idle();
    test_reset();
    test_pass_through();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap_around();
    test_flush_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_out_fifo.md
# reg_out_fifo

Parametrised output-register stage that replaces the single-cycle output shift register at the machine boundary. It captures fire-and-forget result words (valid + data) from the execution pipeline, buffers up to DEPTH of them, and presents them to the outside world through a valid/ready handshake. Words arriving while the buffer is full are dropped and counted. Minimum latency equals the one-clock shift of the previous generation.

## Interface
Parameters:
- DATA_W, 8: width of one output data word (t_data width in the default build).
- DEPTH, 4: buffer entries; power of two, ≥2.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of buffer contents and status.
- in_valid  in  1  producer word valid; no backpressure toward the producer.
- in_data  in  DATA_W  producer word.
- out_valid  out  1  head word available.
- out_data  out  DATA_W  head word; 0 when out_valid=0.
- out_ready  in  1  consumer accepts the head word.
- level  out  $clog2(DEPTH+1)  number of stored words.
- full  out  1  level==DEPTH.
- overflow  out  1  sticky; set on first drop.
- drop_cnt  out  CNT_W  number of dropped words, saturating at all-ones.

## Operation
- Storage: DEPTH×DATA_W array, write pointer and read pointer of $clog2(DEPTH) bits each, wrapping naturally modulo DEPTH, plus a level counter. The array is not reset.
- push = in_valid & ~flush & (~full | pop).
- pop = out_valid & out_ready & ~flush.
- On push: mem[wr_ptr] ← in_data, wr_ptr+1. On pop: rd_ptr+1. level ← level + push − pop.
- Full with simultaneous pop: the incoming word is accepted and level stays DEPTH. No drop occurs.
- Full without pop and in_valid=1 (flush=0): the word is discarded, overflow ← 1, and drop_cnt increments unless it is already all-ones.
- out_valid = (level≠0). out_data = mem[rd_ptr] when out_valid=1, else 0.
- Order: strict FIFO. No word is duplicated, reordered, or altered.
- flush=1 (highest priority): pointers, level, overflow and drop_cnt are cleared on that edge. in_valid in the same cycle is discarded and not counted as a drop. out_ready in that cycle has no effect.
- Empty with out_ready=1: nothing happens. Read pointer and level do not underflow.
- States, derived from level: EMPTY (0), PARTIAL (1..DEPTH−1), FULL (DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop at level DEPTH−1.
  - FULL→PARTIAL on pop without push.
  - PARTIAL→EMPTY on pop without push at level 1.
  - Any state→EMPTY on flush.

## Timing
- Reset (reset_n low, asynchronous assert, release synchronous to clock): out_valid=0, out_data=0, level=0, full=0, overflow=0, drop_cnt=0, pointers=0.
- Reset asserted mid-operation discards all buffered words immediately, without waiting for a clock edge.
- Latency: a word sampled with in_valid at edge k into an empty buffer appears on out_valid/out_data right after edge k. This is one cycle, identical to the previous shift-register stage.
- Throughput: one word per clock in each direction, sustained indefinitely when out_ready is held at 1.
- Handshake: a word transfers on an edge where out_valid & out_ready are both high. out_data is stable while out_valid=1 and out_ready=0. out_valid never drops without a pop, flush or reset.
- Status outputs (level, full, overflow, drop_cnt) are registered and reflect the state after the last edge.

## Test plan
- Pass-through: out_ready=1; push 0x11, 0x22, 0x33 on consecutive edges -> each word appears one cycle later, in order, with out_valid high for 3 cycles and level ≤1.
- Fill/overflow: DEPTH=4, out_ready=0; push 0xA0..0xA5 -> full=1 after the 4th push, overflow=1, drop_cnt=2. Then release out_ready -> exactly 0xA0, 0xA1, 0xA2, 0xA3 drain.
- Full with simultaneous push and pop: at level 4, out_ready=1 and push 0xB0 -> 0xB0 is accepted, drop_cnt unchanged, level stays 4, and 0xB0 is output last.
- Wrap-around: 3×DEPTH pushes interleaved with random out_ready -> the output stream equals the input stream with no loss, and pointers wrap correctly.
- Flush and saturation: CNT_W=2; hold full and push 5 extra words -> drop_cnt=3 (saturated). Then flush with in_valid=1 -> level=0, out_valid=0, overflow=0, drop_cnt=0 on the next cycle, and the flushed-cycle word is absent.
- Asynchronous reset at level 3 mid-transfer -> all outputs 0 immediately. The first post-reset push of 0x5A emerges alone after one cycle.
